// File: rtl/march_bist_engine.sv
// March C- BIST engine: owns the RAM buses while busy, runs w0/r0w1/r1w0/r0w1/r1w0/r0
// over addresses 0..DEPTH-1. Optional failure log enabled by BIST_FAIL_LOG_EN.
module march_bist_engine #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2**ADDR_W,
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bg,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_act,
  output logic [FCNT_W-1:0] fail_cnt,
  input  logic [ADDR_W-1:0] f_rd_addr,
  input  logic [ADDR_W-1:0] f_wr_addr,
  input  logic              f_wr_en,
  input  logic [DATA_W-1:0] f_wr_data,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic              ram_wr_en,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, M4, M5, DRAIN} state_t;

  state_t            state, state_n, nxt;
  logic [ADDR_W-1:0] addr, addr_n, nxt_addr, term;
  logic              phase, phase_n;
  logic [DATA_W-1:0] bg_q;
  logic              rd_go, wr_go, rd_inv, wr_inv, down, two_op, active;
  logic [DATA_W-1:0] wr_val, rd_exp;
  logic              start_go, mismatch;
  logic              cmp_valid;
  logic [DATA_W-1:0] cmp_exp;

  always_comb begin
    state_n  = state;
    addr_n   = addr;
    phase_n  = phase;
    rd_go    = 1'b0;
    wr_go    = 1'b0;
    rd_inv   = 1'b0;
    wr_inv   = 1'b0;
    down     = 1'b0;
    two_op   = 1'b0;
    active   = 1'b1;
    nxt      = IDLE;
    nxt_addr = '0;
    term     = LAST;
    case (state)
      IDLE: begin
        active = 1'b0;
        if (start) begin
          state_n = M0;
          addr_n  = '0;
          phase_n = 1'b0;
        end
      end
      M0: begin
        wr_go = 1'b1;
        nxt   = M1;
      end
      M1: begin
        two_op = 1'b1;
        wr_inv = 1'b1;
        nxt    = M2;
      end
      M2: begin
        two_op   = 1'b1;
        rd_inv   = 1'b1;
        nxt      = M3;
        nxt_addr = LAST;
      end
      M3: begin
        two_op   = 1'b1;
        wr_inv   = 1'b1;
        down     = 1'b1;
        term     = '0;
        nxt      = M4;
        nxt_addr = LAST;
      end
      M4: begin
        two_op = 1'b1;
        rd_inv = 1'b1;
        down   = 1'b1;
        term   = '0;
        nxt    = M5;
      end
      M5: begin
        rd_go = 1'b1;
        nxt   = DRAIN;
      end
      DRAIN: begin
        active  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        active  = 1'b0;
        state_n = IDLE;
      end
    endcase

    if (two_op) begin
      rd_go = !phase;
      wr_go = phase;
    end

    // Phase 0 of a two-op element only reads; the address moves after the write.
    if (two_op && !phase) begin
      phase_n = 1'b1;
    end else if (active) begin
      phase_n = 1'b0;
      if (addr == term) begin
        state_n = nxt;
        addr_n  = nxt_addr;
      end else begin
        addr_n = down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
      end
    end
  end

  assign wr_val   = wr_inv ? ~bg_q : bg_q;
  assign rd_exp   = rd_inv ? ~bg_q : bg_q;
  assign start_go = (state == IDLE) && start;
  assign mismatch = cmp_valid && (ram_rd_data != cmp_exp);
  assign busy     = (state != IDLE);

  assign ram_rd_addr = busy ? addr   : f_rd_addr;
  assign ram_wr_addr = busy ? addr   : f_wr_addr;
  assign ram_wr_en   = busy ? wr_go  : f_wr_en;
  assign ram_wr_data = busy ? wr_val : f_wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      phase     <= 1'b0;
      bg_q      <= '0;
      cmp_valid <= 1'b0;
      cmp_exp   <= '0;
      done      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      phase     <= phase_n;
      cmp_valid <= rd_go;
      cmp_exp   <= rd_exp;
      if (start_go) bg_q <= bg;
      if (start_go)            done <= 1'b0;
      else if (state == DRAIN) done <= 1'b1;
      if (start_go)      fail <= 1'b0;
      else if (mismatch) fail <= 1'b1;
    end
  end

`ifdef BIST_FAIL_LOG_EN
  logic [ADDR_W-1:0] cmp_addr;
  logic [ADDR_W-1:0] log_addr;
  logic [DATA_W-1:0] log_exp, log_act;
  logic [FCNT_W-1:0] log_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_addr <= '0;
      log_addr <= '0;
      log_exp  <= '0;
      log_act  <= '0;
      log_cnt  <= '0;
    end else begin
      cmp_addr <= addr;
      if (start_go) begin
        log_addr <= '0;
        log_exp  <= '0;
        log_act  <= '0;
        log_cnt  <= '0;
      end else if (mismatch) begin
        if (log_cnt != '1) log_cnt <= log_cnt + FCNT_W'(1);
        // Only the first miscompare of a test is recorded.
        if (!fail) begin
          log_addr <= cmp_addr;
          log_exp  <= cmp_exp;
          log_act  <= ram_rd_data;
        end
      end
    end
  end

  assign fail_addr = log_addr;
  assign fail_exp  = log_exp;
  assign fail_act  = log_act;
  assign fail_cnt  = log_cnt;
`else
  assign fail_addr = '0;
  assign fail_exp  = '0;
  assign fail_act  = '0;
  assign fail_cnt  = '0;
`endif

endmodule

// File: tb/tb_march_bist_engine.sv
// Bench for march_bist_engine: table vectors, randomized faults against a March C- model,
// and hand sequences for reset, re-start, functional isolation and counter saturation.
module tb_march_bist_engine;
  localparam int AW  = 5;
  localparam int DW  = 8;
  localparam int DEP = 16;
  localparam int FW  = 8;
`ifdef BIST_FAIL_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, start = 1'b0;
  logic [DW-1:0] bg_in = '0;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_exp, fail_act;
  logic [FW-1:0] fail_cnt;
  logic [AW-1:0] f_rd_addr = '0, f_wr_addr = '0;
  logic          f_wr_en = 1'b0;
  logic [DW-1:0] f_wr_data = '0;
  logic [AW-1:0] ram_rd_addr, ram_wr_addr;
  logic          ram_wr_en;
  logic [DW-1:0] ram_wr_data, rd_q;

  march_bist_engine #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .FCNT_W(FW)) dut (
    .clk(clk), .rst(rst), .start(start), .bg(bg_in),
    .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
    .fail_exp(fail_exp), .fail_act(fail_act), .fail_cnt(fail_cnt),
    .f_rd_addr(f_rd_addr), .f_wr_addr(f_wr_addr), .f_wr_en(f_wr_en), .f_wr_data(f_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_wr_addr(ram_wr_addr), .ram_wr_en(ram_wr_en),
    .ram_wr_data(ram_wr_data), .ram_rd_data(rd_q));

  // Second engine with a 2-bit fail counter and a RAM whose output is stuck at 0xFF.
  logic          start2 = 1'b0;
  logic          busy2, done2, fail2;
  logic [3:0]    fail_addr2, rd_addr2, wr_addr2;
  logic [DW-1:0] fail_exp2, fail_act2, wr_data2;
  logic [1:0]    fail_cnt2;
  logic          wr_en2;
  logic [DW-1:0] rd_ff = 8'hFF;

  march_bist_engine #(.ADDR_W(4), .DATA_W(DW), .DEPTH(16), .FCNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bg(8'h00),
    .busy(busy2), .done(done2), .fail(fail2), .fail_addr(fail_addr2),
    .fail_exp(fail_exp2), .fail_act(fail_act2), .fail_cnt(fail_cnt2),
    .f_rd_addr(4'd0), .f_wr_addr(4'd0), .f_wr_en(1'b0), .f_wr_data(8'h00),
    .ram_rd_addr(rd_addr2), .ram_wr_addr(wr_addr2), .ram_wr_en(wr_en2),
    .ram_wr_data(wr_data2), .ram_rd_data(rd_ff));

  // RAM with optional stuck-at faults on one address, applied on read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            fault_addr = -1;
  logic [DW-1:0] s1m = '0, s0m = '0;
  always @(posedge clk) begin
    logic [DW-1:0] v;
    v = mem[ram_rd_addr];
    if (int'(ram_rd_addr) == fault_addr) v = (v & ~s0m) | s1m;
    rd_q <= v;
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
  end

  int checks = 0, failures = 0;
  int leak = 0;
  bit mon_en = 1'b0;
  always @(negedge clk)
    if (mon_en && busy && ram_wr_en && int'(ram_wr_addr) >= DEP) leak++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Start a test, optionally re-pulse start at busy cycle 'repulse', count busy cycles.
  task automatic run(input logic [DW-1:0] bgv, input int repulse, output int cyc);
    @(negedge clk);
    bg_in = bgv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bg_in = ~bgv;
    cyc = 0;
    while (busy && cyc < 2000) begin
      cyc++;
      start = (cyc == repulse);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  // March C- applied to a word array; results follow the element definitions directly.
  task automatic model(input logic [DW-1:0] bgv, input int fa, input logic [DW-1:0] s1,
                       input logic [DW-1:0] s0, input int cmax,
                       output bit ef, output int eaddr, output logic [DW-1:0] eexp,
                       output logic [DW-1:0] eact, output int ecnt);
    logic [DW-1:0] m [DEP];
    logic [DW-1:0] rv, x;
    bit up;
    ef = 1'b0; eaddr = 0; eexp = '0; eact = '0; ecnt = 0;
    for (int e = 0; e < 6; e++) begin
      up = (e != 3) && (e != 4);
      for (int i = 0; i < DEP; i++) begin
        int a;
        a = up ? i : DEP - 1 - i;
        if (e > 0) begin
          x  = (e == 1 || e == 3 || e == 5) ? bgv : ~bgv;
          rv = m[a];
          if (a == fa) rv = (rv & ~s0) | s1;
          if (rv != x) begin
            if (!ef) begin eaddr = a; eexp = x; eact = rv; end
            ef = 1'b1;
            if (ecnt < cmax) ecnt++;
          end
        end
        if (e == 0 || e == 2 || e == 4) m[a] = bgv;
        else if (e == 1 || e == 3) m[a] = ~bgv;
      end
    end
  endtask

  task automatic check_status(input string tag, input bit ef, input int eaddr,
                              input logic [DW-1:0] eexp, input logic [DW-1:0] eact,
                              input int ecnt);
    check({tag, "_done"}, done, 1);
    check({tag, "_fail"}, fail, ef);
    check({tag, "_fail_addr"}, fail_addr, LOG ? eaddr : 0);
    check({tag, "_fail_exp"}, fail_exp, LOG ? eexp : 0);
    check({tag, "_fail_act"}, fail_act, LOG ? eact : 0);
    check({tag, "_fail_cnt"}, fail_cnt, LOG ? ecnt : 0);
  endtask

  typedef struct {
    logic [DW-1:0] bgv;
    int            fa;
    logic [DW-1:0] s1, s0;
    bit            ef;
    int            eaddr;
    logic [DW-1:0] eexp, eact;
    int            ecnt;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int cyc;
    bit ef;
    int eaddr, ecnt;
    logic [DW-1:0] eexp, eact;

    tbl[0] = '{8'h00, -1, 8'h00, 8'h00, 1'b0,  0, 8'h00, 8'h00, 0};
    tbl[1] = '{8'h00,  5, 8'h08, 8'h00, 1'b1,  5, 8'h00, 8'h08, 3};
    tbl[2] = '{8'hFF,  5, 8'h08, 8'h00, 1'b1,  5, 8'h00, 8'h08, 2};
    tbl[3] = '{8'h0F,  9, 8'h00, 8'h01, 1'b1,  9, 8'h0F, 8'h0E, 3};
    tbl[4] = '{8'h00, 15, 8'h80, 8'h00, 1'b1, 15, 8'h00, 8'h80, 3};
    tbl[5] = '{8'h00,  0, 8'h00, 8'h80, 1'b1,  0, 8'hFF, 8'h7F, 2};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    check("rst_fail_addr", fail_addr, 0);
    check("rst_fail_exp", fail_exp, 0);
    check("rst_fail_act", fail_act, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    f_rd_addr = 5'd7; f_wr_addr = 5'd9; f_wr_data = 8'h11; f_wr_en = 1'b1;
    #1;
    check("mux_rd_addr", ram_rd_addr, 7);
    check("mux_wr_addr", ram_wr_addr, 9);
    check("mux_wr_data", ram_wr_data, 8'h11);
    check("mux_wr_en", ram_wr_en, 1);
    @(negedge clk);
    f_wr_en = 1'b0;

    for (int i = 0; i < 6; i++) begin
      fault_addr = tbl[i].fa; s1m = tbl[i].s1; s0m = tbl[i].s0;
      run(tbl[i].bgv, -1, cyc);
      check($sformatf("tbl%0d_cycles", i), cyc, 10*DEP + 1);
      check_status($sformatf("tbl%0d", i), tbl[i].ef, tbl[i].eaddr, tbl[i].eexp,
                   tbl[i].eact, tbl[i].ecnt);
    end

    for (int i = 0; i < 10; i++) begin
      logic [DW-1:0] bgv, mask;
      bgv  = DW'($urandom);
      mask = DW'(1) << $urandom_range(0, DW-1);
      fault_addr = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, DEP-1));
      if ($urandom_range(0, 1) == 1) begin s1m = mask; s0m = '0; end
      else begin s1m = '0; s0m = mask; end
      model(bgv, fault_addr, s1m, s0m, (1 << FW) - 1, ef, eaddr, eexp, eact, ecnt);
      run(bgv, -1, cyc);
      check($sformatf("rnd%0d_cycles", i), cyc, 10*DEP + 1);
      check_status($sformatf("rnd%0d", i), ef, eaddr, eexp, eact, ecnt);
    end

    // Re-pulsed start and functional writes outside the tested range while busy.
    fault_addr = -1; s1m = '0; s0m = '0;
    f_wr_addr = 5'd20; f_wr_data = 8'h5A; f_wr_en = 1'b1;
    leak = 0; mon_en = 1'b1;
    run(8'h3C, 50, cyc);
    f_wr_en = 1'b0; mon_en = 1'b0;
    check("repulse_cycles", cyc, 10*DEP + 1);
    check("repulse_no_func_write", leak, 0);
    check_status("repulse", 1'b0, 0, 8'h00, 8'h00, 0);

    // Reset 40 cycles into a test that already has a miscompare.
    fault_addr = 5; s1m = 8'h08; s0m = '0;
    @(negedge clk);
    bg_in = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_fail", fail, 1);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_fail", fail, 0);
    check("midrst_fail_cnt", fail_cnt, 0);
    check("midrst_fail_addr", fail_addr, 0);
    f_wr_addr = 5'd3; f_wr_data = 8'hA5; f_wr_en = 1'b1;
    @(negedge clk);
    f_wr_en = 1'b0; f_rd_addr = 5'd3;
    @(negedge clk);
    check("func_readback", rd_q, 8'hA5);
    check("func_idle_busy", busy, 0);
    fault_addr = -1; s1m = '0;

    // Saturating 2-bit counter; every r0 read miscompares.
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0;
    while (busy2 && cyc < 2000) begin
      cyc++;
      @(negedge clk);
    end
    check("sat_cycles", cyc, 161);
    check("sat_done", done2, 1);
    check("sat_fail", fail2, 1);
    check("sat_fail_cnt", fail_cnt2, LOG ? 3 : 0);
    check("sat_fail_addr", fail_addr2, 0);
    check("sat_fail_exp", fail_exp2, 0);
    check("sat_fail_act", fail_act2, LOG ? 8'hFF : 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
